// File: rtl/peripheral_memory_pkg.sv
// Shared types and default geometry for the peripheral memory interface.
// Initiators and peripherals import this so they agree on widths and opcodes.
package peripheral_memory_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  localparam int DEFAULT_DATAWIDTH    = 32;
  localparam int DEFAULT_DATADEPTH    = 256;
  localparam int DEFAULT_ADDRESSWIDTH = $clog2(DEFAULT_DATADEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only
// when a pop happens in the same cycle. DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  rdPtr_q, wrPtr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             doPush, doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNTW'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign count  = count_q;
  // Head reads as zero when empty so downstream data is clean out of reset.
  assign rdata  = empty ? '0 : mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q + CNTW'(doPush) - CNTW'(doPop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

endmodule

// File: rtl/peripheral_memory_initiator.sv
// Host-side initiator: queues read/write commands, issues registered strobes to a
// peripheral, and returns read data in order through a credit-protected response FIFO.
module peripheral_memory_initiator
  import peripheral_memory_pkg::*;
#(
  parameter int DATAWIDTH    = DEFAULT_DATAWIDTH,
  parameter int DATADEPTH    = DEFAULT_DATADEPTH,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [DATAWIDTH-1:0]    cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATAWIDTH-1:0]    rsp_data,
  output logic                    mem_clk,
  output logic                    mem_reset,
  output logic [ADDRESSWIDTH-1:0] mem_address,
  output logic [DATAWIDTH-1:0]    mem_data_in,
  input  logic [DATAWIDTH-1:0]    mem_data_out,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic                    busy
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    mem_op_t                 op;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0]    data;
  } cmd_t;

  cmd_t                    cmdIn, cmdHead;
  logic                    cmdPush, cmdFull, cmdEmpty;
  logic [CNTW-1:0]         cmdCount;
  logic                    rspPush, rspPop, rspFull, rspEmpty;
  logic [CNTW-1:0]         rspCount;
  logic                    issue, issueRead, issueWrite, capture;
  logic [CNTW-1:0]         credit_q, credit_d;
  logic [READ_LATENCY-1:0] rdPipe_q, rdPipe_d;
  logic [ADDRESSWIDTH-1:0] address_q;
  logic [DATAWIDTH-1:0]    dataIn_q;
  logic                    writeEn_q, readEn_q;

  assign mem_clk   = clk;
  assign mem_reset = reset;

  assign cmdIn.op   = cmd_write ? OP_WRITE : OP_READ;
  assign cmdIn.addr = cmd_address;
  assign cmdIn.data = cmd_data;
  assign cmd_ready  = !cmdFull && !reset;
  assign cmdPush    = cmd_valid && cmd_ready;

  sync_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_cmdFifo (
    .clk  (clk),
    .rst  (reset),
    .push (cmdPush),
    .pop  (issue),
    .wdata(cmdIn),
    .rdata(cmdHead),
    .full (cmdFull),
    .empty(cmdEmpty),
    .count(cmdCount)
  );

  // A read may only leave the queue when a response slot is guaranteed;
  // a slot freed by this cycle's pop is already usable.
  assign rspPop     = rsp_valid && rsp_ready;
  assign issue      = !cmdEmpty && ((cmdHead.op == OP_WRITE) || (credit_q != '0) || rspPop);
  assign issueRead  = issue && (cmdHead.op == OP_READ);
  assign issueWrite = issue && (cmdHead.op == OP_WRITE);
  assign capture    = rdPipe_q[READ_LATENCY-1];
  assign rspPush    = capture && (!rspFull || rspPop);

  always_comb begin
    credit_d    = credit_q - CNTW'(issueRead) + CNTW'(rspPop);
    rdPipe_d    = '0;
    rdPipe_d[0] = readEn_q;
    for (int i = 1; i < READ_LATENCY; i++) rdPipe_d[i] = rdPipe_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      dataIn_q  <= '0;
      writeEn_q <= 1'b0;
      readEn_q  <= 1'b0;
      rdPipe_q  <= '0;
      credit_q  <= CNTW'(FIFO_DEPTH);
    end else begin
      writeEn_q <= issueWrite;
      readEn_q  <= issueRead;
      rdPipe_q  <= rdPipe_d;
      credit_q  <= credit_d;
      if (issue)      address_q <= cmdHead.addr;
      if (issueWrite) dataIn_q  <= cmdHead.data;
    end
  end

  sync_fifo #(
    .WIDTH(DATAWIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_rspFifo (
    .clk  (clk),
    .rst  (reset),
    .push (rspPush),
    .pop  (rspPop),
    .wdata(mem_data_out),
    .rdata(rsp_data),
    .full (rspFull),
    .empty(rspEmpty),
    .count(rspCount)
  );

  assign rsp_valid    = !rspEmpty;
  assign mem_address  = address_q;
  assign mem_data_in  = dataIn_q;
  assign mem_write_en = writeEn_q;
  assign mem_read_en  = readEn_q;
  assign busy         = (cmdCount != '0) || readEn_q || writeEn_q ||
                        (|rdPipe_q) || (rspCount != '0);

endmodule

// File: tb/tb_peripheral_memory_initiator.sv
// Scoreboard bench: two initiators (read latency 1 and 3) each driving a behavioural RAM;
// expected write strobes and read responses are queued at command acceptance.
module tb_peripheral_memory_initiator;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmdValid[2], cmdReady[2], cmdWrite[2];
  logic [AW-1:0] cmdAddress[2];
  logic [DW-1:0] cmdData[2];
  logic          rspValid[2], rspReady[2];
  logic [DW-1:0] rspData[2];
  logic          memClk[2], memReset[2];
  logic [AW-1:0] memAddress[2];
  logic [DW-1:0] memDataIn[2], memDataOut[2];
  logic          memWriteEn[2], memReadEn[2], busy[2];

  logic [DW-1:0] ram[2][256];
  logic [DW-1:0] shadow[2][256];
  logic [DW-1:0] stage[2][3];

  logic [DW-1:0]    expRsp0[$], expRsp1[$];
  logic [AW+DW-1:0] expWr0[$], expWr1[$];

  int checks = 0;
  int errors = 0;
  int rdPulses[2], wrPulses[2], wrStreak[2], maxWrStreak[2], rspSeen[2];

  always #5 clk = ~clk;

  peripheral_memory_initiator #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmdValid[0]), .cmd_ready(cmdReady[0]), .cmd_write(cmdWrite[0]),
    .cmd_address(cmdAddress[0]), .cmd_data(cmdData[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_data(rspData[0]),
    .mem_clk(memClk[0]), .mem_reset(memReset[0]), .mem_address(memAddress[0]),
    .mem_data_in(memDataIn[0]), .mem_data_out(memDataOut[0]),
    .mem_write_en(memWriteEn[0]), .mem_read_en(memReadEn[0]), .busy(busy[0])
  );

  peripheral_memory_initiator #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmdValid[1]), .cmd_ready(cmdReady[1]), .cmd_write(cmdWrite[1]),
    .cmd_address(cmdAddress[1]), .cmd_data(cmdData[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_data(rspData[1]),
    .mem_clk(memClk[1]), .mem_reset(memReset[1]), .mem_address(memAddress[1]),
    .mem_data_in(memDataIn[1]), .mem_data_out(memDataOut[1]),
    .mem_write_en(memWriteEn[1]), .mem_read_en(memReadEn[1]), .busy(busy[1])
  );

  // Behavioural peripherals: data_out follows the address READ_LATENCY cycles later.
  assign memDataOut[0] = stage[0][0];
  assign memDataOut[1] = stage[1][2];

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (memWriteEn[s]) ram[s][memAddress[s]] <= memDataIn[s];
      stage[s][0] <= ram[s][memAddress[s]];
      stage[s][1] <= stage[s][0];
      stage[s][2] <= stage[s][1];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: strobe exclusivity, write strobe contents and read responses against the queues.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (memWriteEn[s] || memReadEn[s])
        checkOutput("strobes_exclusive", 64'(memWriteEn[s] && memReadEn[s]), 64'd0);
      if (memWriteEn[s]) begin
        wrPulses[s]++;
        wrStreak[s]++;
        if (wrStreak[s] > maxWrStreak[s]) maxWrStreak[s] = wrStreak[s];
        if ((s == 0 && expWr0.size() == 0) || (s == 1 && expWr1.size() == 0)) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write dut%0d: got addr 0x%0h, required none", s, memAddress[s]);
        end else begin
          checkOutput("write_strobe", {memAddress[s], memDataIn[s]},
                      (s == 0) ? expWr0.pop_front() : expWr1.pop_front());
        end
      end else begin
        wrStreak[s] = 0;
      end
      if (memReadEn[s]) rdPulses[s]++;
      if (rspValid[s] && rspReady[s]) begin
        rspSeen[s]++;
        if ((s == 0 && expRsp0.size() == 0) || (s == 1 && expRsp1.size() == 0)) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_rsp dut%0d: got 0x%0h, required none", s, rspData[s]);
        end else begin
          checkOutput("rsp_data", rspData[s], (s == 0) ? expRsp0.pop_front() : expRsp1.pop_front());
        end
      end
    end
  end

  // Drive one command and hold it until accepted; expectations are queued at acceptance.
  task automatic applyStimulus(input int sel, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    int  waited   = 0;
    bit  accepted = 0;
    cmdValid[sel]   = 1'b1;
    cmdWrite[sel]   = wr;
    cmdAddress[sel] = addr;
    cmdData[sel]    = data;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (cmdReady[sel]) begin
        @(posedge clk);
        accepted = 1;
      end else begin
        waited++;
      end
    end
    if (!accepted) begin
      checks++; errors++;
      $display("[TB] FAIL cmd_accept_timeout dut%0d: got no cmd_ready, required ready within 200 cycles", sel);
    end else if (wr) begin
      shadow[sel][addr] = data;
      if (sel == 0) expWr0.push_back({addr, data}); else expWr1.push_back({addr, data});
    end else begin
      if (sel == 0) expRsp0.push_back(shadow[0][addr]); else expRsp1.push_back(shadow[1][addr]);
    end
    #1;
    cmdValid[sel] = 1'b0;
  endtask

  task automatic waitIdle(input int sel);
    int  cycles = 0;
    bit  idle   = 0;
    while (!idle && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      idle = !busy[sel] && ((sel == 0) ? (expRsp0.size() == 0 && expWr0.size() == 0)
                                       : (expRsp1.size() == 0 && expWr1.size() == 0));
    end
    checkOutput("drain_within_budget", 64'(idle), 64'd1);
  endtask

  initial begin
    int base, seenBase;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        ram[s][i]    = 32'hC0DE_0000 + i;
        shadow[s][i] = 32'hC0DE_0000 + i;
      end
      for (int k = 0; k < 3; k++) stage[s][k] = '0;
      cmdValid[s] = 0; cmdWrite[s] = 0; cmdAddress[s] = '0; cmdData[s] = '0;
      rspReady[s] = 1;
      rdPulses[s] = 0; wrPulses[s] = 0; wrStreak[s] = 0; maxWrStreak[s] = 0; rspSeen[s] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 64'(cmdReady[0]), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rspValid[0]), 64'd0);
    checkOutput("reset_rsp_data", rspData[0], 64'd0);
    checkOutput("reset_mem_address", memAddress[0], 64'd0);
    checkOutput("reset_mem_data_in", memDataIn[0], 64'd0);
    checkOutput("reset_strobes", {memWriteEn[0], memReadEn[0]}, 64'd0);
    checkOutput("reset_busy", 64'(busy[0]), 64'd0);
    checkOutput("mem_reset_passthru", 64'(memReset[0]), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 64'(cmdReady[0]), 64'd1);
    checkOutput("mem_reset_released", 64'(memReset[1]), 64'd0);

    $display("[TB] test 1: single write latency");
    applyStimulus(0, 1'b1, 8'd5, 32'hA5A5_0001);
    checkOutput("t1_no_strobe_yet", 64'(memWriteEn[0]), 64'd0);
    @(posedge clk); #1;
    checkOutput("t1_write_en", 64'(memWriteEn[0]), 64'd1);
    checkOutput("t1_address", memAddress[0], 64'd5);
    checkOutput("t1_data_in", memDataIn[0], 64'hA5A5_0001);
    @(posedge clk); #1;
    checkOutput("t1_strobe_one_cycle", 64'(memWriteEn[0]), 64'd0);
    checkOutput("t1_address_held", memAddress[0], 64'd5);

    $display("[TB] test 2: write then read latency");
    applyStimulus(0, 1'b1, 8'd3, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 8'd3, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t2_rsp_valid_c%0d", k), 64'(rspValid[0]), (k == 3) ? 64'd1 : 64'd0);
    end
    checkOutput("t2_rsp_data", rspData[0], 64'hDEAD_BEEF);
    waitIdle(0);

    $display("[TB] test 3: credit back-pressure");
    rspReady[0] = 0;
    base = rdPulses[0];
    seenBase = rspSeen[0];
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 8'(20 + i), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t3_reads_limited", 64'(rdPulses[0] - base), 64'd4);
    checkOutput("t3_cmd_fifo_full", 64'(cmdReady[0]), 64'd0);
    checkOutput("t3_rsp_valid_held", 64'(rspValid[0]), 64'd1);
    rspReady[0] = 1;
    waitIdle(0);
    checkOutput("t3_all_reads", 64'(rdPulses[0] - base), 64'd8);
    checkOutput("t3_all_rsps", 64'(rspSeen[0] - seenBase), 64'd8);

    $display("[TB] test 4: streaming writes");
    base = wrPulses[0];
    maxWrStreak[0] = 0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 1'b1, 8'(40 + i), 32'h4000_0000 + 32'(i * 32'h11));
    waitIdle(0);
    checkOutput("t4_write_count", 64'(wrPulses[0] - base), 64'd10);
    checkOutput("t4_consecutive", 64'(maxWrStreak[0]), 64'd10);
    applyStimulus(0, 1'b0, 8'd40, 32'h0);
    applyStimulus(0, 1'b0, 8'd49, 32'h0);
    applyStimulus(0, 1'b0, 8'd50, 32'h0);
    waitIdle(0);

    $display("[TB] test 5: reset mid-transfer");
    rspReady[0] = 0;
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 8'(60 + i), 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("t5_strobes_cleared", {memWriteEn[0], memReadEn[0]}, 64'd0);
    checkOutput("t5_rsp_valid_cleared", 64'(rspValid[0]), 64'd0);
    checkOutput("t5_busy_cleared", 64'(busy[0]), 64'd0);
    checkOutput("t5_cmd_ready_low", 64'(cmdReady[0]), 64'd0);
    checkOutput("t5_address_cleared", memAddress[0], 64'd0);
    expRsp0.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    rspReady[0] = 1;
    seenBase = rspSeen[0];
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_no_late_rsp", 64'(rspSeen[0] - seenBase), 64'd0);
    checkOutput("t5_idle_after", 64'(busy[0]), 64'd0);

    $display("[TB] test 6: latency-3 mixed stream");
    seenBase = rspSeen[1];
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1, 8'(100 + i), 32'h6000_0000 + 32'(i * 32'h0101));
      applyStimulus(1, 1'b0, 8'(100 + ((i * 3) % 8)), 32'h0);
    end
    waitIdle(1);
    checkOutput("t6_rsp_count", 64'(rspSeen[1] - seenBase), 64'd8);
    rspReady[1] = 0;
    base = rdPulses[1];
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b0, 8'(100 + i), 32'h0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t6_reads_limited", 64'(rdPulses[1] - base), 64'd4);
    rspReady[1] = 1;
    waitIdle(1);
    checkOutput("t6_all_reads", 64'(rdPulses[1] - base), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required finish within 1000000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
